// File: rtl/ps2_host_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ps2_host_tx : host-to-device PS/2 command-byte transmitter (open-drain oe). |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 9600,
  parameter int START_TIMEOUT  = 1440000,
  parameter int FRAME_TIMEOUT  = 192000,
  parameter int FILTER         = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int              c_FCW      = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [c_FCW-1:0] c_FLT_LAST = c_FCW'(FILTER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_RELEASE
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic       w_fall;
  logic       w_err;

  state_t      r_state;
  logic [20:0] r_cnt;
  logic [3:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_par;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_clk_oe;
  logic        r_dat_oe;
  logic        r_clk_prev;

  assign w_raw = {ps2_dat_i, ps2_clk_i};

  // Index 0 conditions the clock line, index 1 the data line.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic [c_FCW-1:0] r_run;

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_lvl <= 1'b1;
        r_run <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_lvl) begin
          r_run <= '0;
        end else if (r_run == c_FLT_LAST) begin
          r_lvl <= r_s2;
          r_run <= '0;
        end else begin
          r_run <= r_run + 1'b1;
        end
      end
    end

    assign w_lvl[gi] = r_lvl;
  end

  assign w_fall = r_clk_prev & ~w_lvl[0];

  // One timeout budget per phase; a high ack bit is the only protocol error.
  assign w_err = (((r_state == S_REQ) || (r_state == S_SEND) || (r_state == S_ACK) ||
                   (r_state == S_RELEASE)) && (r_cnt == 21'd0)) ||
                 ((r_state == S_ACK) && w_fall && w_lvl[1]);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_par      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= w_lvl[0];
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_err) begin
        r_err    <= 1'b1;
        r_busy   <= 1'b0;
        r_clk_oe <= 1'b0;
        r_dat_oe <= 1'b0;
        r_state  <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (tx_req) begin
              r_data   <= tx_data;
              r_par    <= ~^tx_data;
              // Loaded one short so the clock is held low for exactly INHIBIT_CYCLES.
              r_cnt    <= 21'(INHIBIT_CYCLES - 1);
              r_busy   <= 1'b1;
              r_clk_oe <= 1'b1;
              r_state  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_cnt == 21'd0) begin
              r_clk_oe <= 1'b0;
              r_dat_oe <= 1'b1;
              r_cnt    <= 21'(START_TIMEOUT - 1);
              r_state  <= S_REQ;
            end else begin
              r_cnt <= r_cnt - 21'd1;
            end
          end
          S_REQ: begin
            if (w_fall) begin
              r_dat_oe <= ~r_data[0];
              r_idx    <= 4'd1;
              r_cnt    <= 21'(FRAME_TIMEOUT - 1);
              r_state  <= S_SEND;
            end else begin
              r_cnt <= r_cnt - 21'd1;
            end
          end
          S_SEND: begin
            r_cnt <= r_cnt - 21'd1;
            if (w_fall) begin
              r_idx <= r_idx + 4'd1;
              if (r_idx == 4'd9) begin
                r_dat_oe <= 1'b0;
                r_state  <= S_ACK;
              end else if (r_idx == 4'd8) begin
                r_dat_oe <= ~r_par;
              end else begin
                r_dat_oe <= ~r_data[r_idx[2:0]];
              end
            end
          end
          S_ACK: begin
            r_cnt <= r_cnt - 21'd1;
            if (w_fall) begin
              r_state <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (w_lvl[0] && w_lvl[1]) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 21'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_err     = r_err;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ps2_host_tx : bench for ps2_host_tx with a wired-AND PS/2 device model.  |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module tb_ps2_host_tx;

  localparam int INH    = 200;
  localparam int START  = 3000;
  localparam int FRAME  = 2000;
  localparam int FILTER = 8;
  localparam int HALF   = 40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_i, ps2_dat_i;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0, n_err = 0, t_done = 0, t_err = 0, t_acc = 0;
  int run = 0, inh_len = 0, t_fall11 = 0;
  logic [1:0] oe_at_err = '0;
  logic       dat_at_rel = 1'b0;
  logic       p_busy = 1'b0, p_clk_oe = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus: a line is high only if neither side pulls it low.
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .FRAME_TIMEOUT(FRAME), .FILTER(FILTER)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_req(tx_req),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin n_done++; t_done = cyc; end
    if (tx_err === 1'b1) begin n_err++; t_err = cyc; oe_at_err = {ps2_clk_oe, ps2_dat_oe}; end
    if (tx_busy === 1'b1 && !p_busy) t_acc = cyc;
    if (ps2_clk_oe === 1'b1) run++;
    else begin
      if (p_clk_oe) begin inh_len = run; dat_at_rel = ps2_dat_oe; end
      run = 0;
    end
    p_busy   = (tx_busy === 1'b1);
    p_clk_oe = (ps2_clk_oe === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_bits(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic wait_busy(input logic lvl, input int bound, output bit ok);
    for (int i = 0; i < bound && tx_busy !== lvl; i++) tick();
    ok = (tx_busy === lvl);
  endtask

  task automatic dev_frame(input bit ack_low, input bit glitch, input int nclk,
                           output logic [10:0] bits);
    bit ok;
    bits = '0;
    for (int i = 0; i < INH + 50 && !(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1); i++) tick();
    ok = (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1);
    chk("dev_start_seen", ok, 1);
    repeat (20) tick();
    bits[0] = ps2_dat_i;
    for (int i = 1; i <= 10 && i <= nclk; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      bits[i] = ps2_dat_i;
      if (glitch) begin
        repeat (10) tick();
        dev_clk = 1'b0;
        repeat (5) tick();
        dev_clk = 1'b1;
        repeat (HALF - 15) tick();
      end else begin
        repeat (HALF) tick();
      end
    end
    if (nclk >= 11) begin
      if (ack_low) dev_dat = 1'b0;
      repeat (10) tick();
      dev_clk  = 1'b0;
      t_fall11 = cyc;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      repeat (10) tick();
      dev_dat = 1'b1;
      repeat (HALF) tick();
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit glitch, input bit ack_low,
                           input string tag);
    logic [10:0] got;
    int d0, e0;
    bit ok;
    d0 = n_done;
    e0 = n_err;
    tx_data = b;
    tx_req  = 1'b1;
    wait_busy(1'b1, 10, ok);
    chk({tag, "_accept"}, ok, 1);
    tx_req = 1'b0;
    dev_frame(ack_low, glitch, 11, got);
    wait_busy(1'b0, 200, ok);
    chk({tag, "_idle"}, ok, 1);
    chk({tag, "_bits"}, got, model_bits(b));
    chk({tag, "_inhibit_len"}, inh_len, INH);
    chk({tag, "_dat_at_clk_release"}, dat_at_rel, 1);
    if (ack_low) begin
      chk({tag, "_done_pulses"}, n_done - d0, 1);
      chk({tag, "_err_pulses"}, n_err - e0, 0);
    end else begin
      chk({tag, "_err_pulses"}, n_err - e0, 1);
      chk({tag, "_done_pulses"}, n_done - d0, 0);
      chk({tag, "_err_latency"}, t_err - t_fall11, FILTER + 3);
      chk({tag, "_oe_at_err"}, oe_at_err, 0);
    end
  endtask

  initial begin
    logic [10:0] got;
    logic [7:0]  rb;
    bit          ok;
    int          d0, e0, dt;

    reset_n = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    repeat (3) tick();
    chk("reset_outputs", {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 0);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("idle_outputs", {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 0);

    run_frame(8'hED, 1'b0, 1'b1, "ed");
    run_frame(8'h07, 1'b0, 1'b1, "x07");
    run_frame(8'hFF, 1'b0, 1'b1, "xff");
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      run_frame(rb, 1'($urandom), 1'b1, "rand");
    end

    // Device never clocks: start timeout.
    d0 = n_done;
    e0 = n_err;
    tx_data = 8'h33;
    tx_req  = 1'b1;
    wait_busy(1'b1, 10, ok);
    chk("noclk_accept", ok, 1);
    tx_req = 1'b0;
    for (int i = 0; i < INH + START + 50 && n_err == e0; i++) tick();
    chk("noclk_err_pulses", n_err - e0, 1);
    dt = t_err - t_acc;
    chk("noclk_err_time", (dt >= INH + START - 2 && dt <= INH + START + 2) ? INH + START : dt,
        INH + START);
    chk("noclk_oe_at_err", oe_at_err, 0);
    chk("noclk_done_pulses", n_done - d0, 0);
    chk("noclk_busy", tx_busy, 0);

    // Device leaves data high at the ack clock, with clock glitches throughout.
    run_frame(8'hC3, 1'b1, 1'b0, "nak");

    // Reset mid-frame after bit 3.
    d0 = n_done;
    e0 = n_err;
    tx_data = 8'h3C;
    tx_req  = 1'b1;
    wait_busy(1'b1, 10, ok);
    chk("rst_accept", ok, 1);
    tx_req = 1'b0;
    dev_frame(1'b1, 1'b0, 4, got);
    chk("rst_partial_bits", got[4:0], model_bits(8'h3C) & 11'h01F);
    reset_n = 1'b0;
    tick();
    chk("rst_outputs", {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_pulses", (n_done - d0) + (n_err - e0), 0);
    run_frame(8'h55, 1'b0, 1'b1, "after_rst");

    // Back-to-back with tx_req held high; mid-frame data change must not leak.
    d0 = n_done;
    e0 = n_err;
    tx_data = 8'hAA;
    tx_req  = 1'b1;
    wait_busy(1'b1, 10, ok);
    chk("b2b_accept1", ok, 1);
    repeat (5) tick();
    tx_data = 8'h12;
    dev_frame(1'b1, 1'b0, 11, got);
    chk("b2b_bits1", got, model_bits(8'hAA));
    for (int i = 0; i < 300 && !(n_done > d0 && tx_busy === 1'b1); i++) tick();
    tx_req = 1'b0;
    chk("b2b_second_busy", tx_busy, 1);
    chk("b2b_accept_gap", t_acc - t_done, 1);
    dev_frame(1'b1, 1'b0, 11, got);
    chk("b2b_bits2", got, model_bits(8'h12));
    wait_busy(1'b0, 200, ok);
    chk("b2b_idle", ok, 1);
    chk("b2b_done_pulses", n_done - d0, 2);
    chk("b2b_err_pulses", n_err - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
